// File: rtl/if_stage_gen2.sv
// Instruction-fetch stage: PC register with branch/jump redirect, ROM addressing,
// and the IF/ID pipeline register with a delivered-instruction counter.
module if_stage_gen2 #(
   parameter int          MEMORY_DEPTH = 256,
   parameter logic [31:0] RESET_PC     = 32'h0040_0000,
   parameter int          COUNT_W      = 16,
   localparam int         AW           = $clog2(MEMORY_DEPTH)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               stall,
   input  logic               flush,
   input  logic               branch_taken_M,
   input  logic [31:0]        branch_target_M,
   input  logic               jump_D,
   input  logic [31:0]        jump_target_D,
   output logic [AW-1:0]      imem_addr,
   input  logic [31:0]        imem_data,
   output logic [31:0]        pc_IF,
   output logic [31:0]        instruction_ID,
   output logic [31:0]        pc_plus_4_ID,
   output logic               valid_ID,
   output logic [COUNT_W-1:0] fetch_count,
   output logic               misalign_err
);

   logic        redirect;
   logic [31:0] target;
   logic [31:0] pc_plus_4;

   // The branch resolves later in the pipe, so it wins over a jump seen in ID.
   assign redirect  = branch_taken_M | jump_D;
   assign target    = branch_taken_M ? branch_target_M : jump_target_D;
   assign pc_plus_4 = pc_IF + 32'd4;

   // Word index relative to RESET_PC; truncation makes the ROM wrap.
   assign imem_addr = AW'((pc_IF - RESET_PC) >> 2);

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_IF          <= RESET_PC;
         instruction_ID <= 32'd0;
         pc_plus_4_ID   <= 32'd0;
         valid_ID       <= 1'b0;
         fetch_count    <= '0;
         misalign_err   <= 1'b0;
      end else begin
         if (redirect) begin
            pc_IF <= {target[31:2], 2'b00};
            if (target[1:0] != 2'b00) misalign_err <= 1'b1;
         end else if (!stall) begin
            pc_IF <= pc_plus_4;
         end

         // A redirect squashes the wrong-path word currently being fetched.
         if (redirect || flush) begin
            instruction_ID <= 32'd0;
            pc_plus_4_ID   <= 32'd0;
            valid_ID       <= 1'b0;
         end else if (!stall) begin
            instruction_ID <= imem_data;
            pc_plus_4_ID   <= pc_plus_4;
            valid_ID       <= 1'b1;
            fetch_count    <= fetch_count + COUNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_if_stage_gen2.sv
// Bench for if_stage_gen2: directed scenarios plus a randomized run checked
// against a cycle-level behavioural model of the fetch stage.
module tb_if_stage_gen2;

   localparam logic [31:0] BASE = 32'h0040_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic        branch_taken_M = 1'b0;
   logic [31:0] branch_target_M = 32'd0;
   logic        jump_D = 1'b0;
   logic [31:0] jump_target_D = 32'd0;

   logic [7:0]  imem_addr;
   logic [31:0] imem_data;
   logic [31:0] pc_IF, instruction_ID, pc_plus_4_ID;
   logic        valid_ID, misalign_err;
   logic [15:0] fetch_count;

   logic [1:0]  w_imem_addr;
   logic [31:0] w_imem_data;
   logic [31:0] w_pc_IF, w_instruction_ID, w_pc_plus_4_ID;
   logic        w_valid_ID, w_misalign_err;
   logic [1:0]  w_fetch_count;

   logic [31:0] rom [256];

   int n_checks = 0;
   int n_errors = 0;

   // Behavioural model state
   logic [31:0] m_pc, m_instr, m_pc4;
   logic        m_valid, m_err;
   int          m_count;

   always #5 clk = ~clk;

   assign imem_data   = rom[imem_addr];
   assign w_imem_data = {30'd0, w_imem_addr} + 32'd1;

   if_stage_gen2 dut (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush),
      .branch_taken_M(branch_taken_M), .branch_target_M(branch_target_M),
      .jump_D(jump_D), .jump_target_D(jump_target_D),
      .imem_addr(imem_addr), .imem_data(imem_data), .pc_IF(pc_IF),
      .instruction_ID(instruction_ID), .pc_plus_4_ID(pc_plus_4_ID),
      .valid_ID(valid_ID), .fetch_count(fetch_count), .misalign_err(misalign_err)
   );

   if_stage_gen2 #(.MEMORY_DEPTH(4), .COUNT_W(2)) dut_w (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush),
      .branch_taken_M(branch_taken_M), .branch_target_M(branch_target_M),
      .jump_D(jump_D), .jump_target_D(jump_target_D),
      .imem_addr(w_imem_addr), .imem_data(w_imem_data), .pc_IF(w_pc_IF),
      .instruction_ID(w_instruction_ID), .pc_plus_4_ID(w_pc_plus_4_ID),
      .valid_ID(w_valid_ID), .fetch_count(w_fetch_count), .misalign_err(w_misalign_err)
   );

   // Advance the model by one clock from the current inputs, then let the DUT clock.
   task automatic tick();
      logic [31:0] tgt, off;
      bit redir;
      if (reset) begin
         m_pc = BASE; m_instr = 0; m_pc4 = 0; m_valid = 0; m_count = 0; m_err = 0;
      end else begin
         redir = branch_taken_M || jump_D;
         tgt   = branch_taken_M ? branch_target_M : jump_target_D;
         off   = m_pc - BASE;
         if (redir || flush) begin
            m_instr = 0; m_pc4 = 0; m_valid = 0;
         end else if (!stall) begin
            m_instr = rom[int'((off / 4) % 256)];
            m_pc4   = m_pc + 4;
            m_valid = 1;
            m_count = (m_count + 1) % 65536;
         end
         if (redir) begin
            if (tgt % 4 != 0) m_err = 1;
            m_pc = tgt - (tgt % 4);
         end else if (!stall) begin
            m_pc = m_pc + 4;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input bit rst, input bit b, input logic [31:0] bt,
                         input bit j, input logic [31:0] jt, input bit st, input bit fl);
      reset = rst; branch_taken_M = b; branch_target_M = bt;
      jump_D = j; jump_target_D = jt; stall = st; flush = fl;
   endtask

   task automatic fill_rom_seq();
      for (int k = 0; k < 256; k++) rom[k] = 32'(k + 1);
   endtask

   task automatic test_reset();
      set_in(1, 0, 0, 0, 0, 0, 0);
      tick(); tick();
      n_checks++; if (pc_IF !== BASE) begin n_errors++; $display("FAIL reset_pc: got %h expected %h", pc_IF, BASE); end
      n_checks++; if (imem_addr !== 8'd0) begin n_errors++; $display("FAIL reset_addr: got %0d expected 0", imem_addr); end
      n_checks++; if (instruction_ID !== 32'd0) begin n_errors++; $display("FAIL reset_instr: got %h expected 0", instruction_ID); end
      n_checks++; if (pc_plus_4_ID !== 32'd0) begin n_errors++; $display("FAIL reset_pc4: got %h expected 0", pc_plus_4_ID); end
      n_checks++; if (valid_ID !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b expected 0", valid_ID); end
      n_checks++; if (fetch_count !== 16'd0) begin n_errors++; $display("FAIL reset_count: got %0d expected 0", fetch_count); end
      n_checks++; if (misalign_err !== 1'b0) begin n_errors++; $display("FAIL reset_err: got %b expected 0", misalign_err); end
   endtask

   task automatic test_sequential();
      set_in(1, 0, 0, 0, 0, 0, 0); tick();
      set_in(0, 0, 0, 0, 0, 0, 0);
      for (int n = 0; n < 8; n++) begin
         n_checks++; if (pc_IF !== BASE + 32'(4 * n)) begin n_errors++; $display("FAIL seq_pc[%0d]: got %h expected %h", n, pc_IF, BASE + 32'(4 * n)); end
         n_checks++; if (imem_addr !== 8'(n)) begin n_errors++; $display("FAIL seq_addr[%0d]: got %0d expected %0d", n, imem_addr, n); end
         n_checks++; if (fetch_count !== 16'(n)) begin n_errors++; $display("FAIL seq_count[%0d]: got %0d expected %0d", n, fetch_count, n); end
         if (n > 0) begin
            n_checks++; if (instruction_ID !== 32'(n)) begin n_errors++; $display("FAIL seq_instr[%0d]: got %h expected %h", n, instruction_ID, 32'(n)); end
            n_checks++; if (pc_plus_4_ID !== BASE + 32'(4 * n)) begin n_errors++; $display("FAIL seq_pc4[%0d]: got %h expected %h", n, pc_plus_4_ID, BASE + 32'(4 * n)); end
            n_checks++; if (valid_ID !== 1'b1) begin n_errors++; $display("FAIL seq_valid[%0d]: got %b expected 1", n, valid_ID); end
         end
         tick();
      end
   endtask

   task automatic test_stall();
      set_in(1, 0, 0, 0, 0, 0, 0); tick();
      set_in(0, 0, 0, 0, 0, 0, 0); tick(); tick();
      set_in(0, 0, 0, 0, 0, 1, 0);
      for (int c = 0; c < 3; c++) begin
         tick();
         n_checks++; if (pc_IF !== BASE + 32'h8) begin n_errors++; $display("FAIL stall_pc[%0d]: got %h expected %h", c, pc_IF, BASE + 32'h8); end
         n_checks++; if (instruction_ID !== 32'd2) begin n_errors++; $display("FAIL stall_instr[%0d]: got %h expected 2", c, instruction_ID); end
         n_checks++; if (fetch_count !== 16'd2) begin n_errors++; $display("FAIL stall_count[%0d]: got %0d expected 2", c, fetch_count); end
      end
      set_in(0, 0, 0, 0, 0, 0, 0); tick();
      n_checks++; if (pc_IF !== BASE + 32'hC) begin n_errors++; $display("FAIL stall_resume_pc: got %h expected %h", pc_IF, BASE + 32'hC); end
      n_checks++; if (instruction_ID !== 32'd3) begin n_errors++; $display("FAIL stall_resume_instr: got %h expected 3", instruction_ID); end
      n_checks++; if (fetch_count !== 16'd3) begin n_errors++; $display("FAIL stall_resume_count: got %0d expected 3", fetch_count); end
   endtask

   task automatic test_branch_jump();
      set_in(0, 1, BASE + 32'h100, 1, BASE + 32'h200, 1, 0); tick();
      n_checks++; if (pc_IF !== BASE + 32'h100) begin n_errors++; $display("FAIL bj_pc: got %h expected %h", pc_IF, BASE + 32'h100); end
      n_checks++; if (imem_addr !== 8'd64) begin n_errors++; $display("FAIL bj_addr: got %0d expected 64", imem_addr); end
      n_checks++; if (valid_ID !== 1'b0) begin n_errors++; $display("FAIL bj_valid: got %b expected 0", valid_ID); end
      n_checks++; if (instruction_ID !== 32'd0) begin n_errors++; $display("FAIL bj_instr: got %h expected 0", instruction_ID); end
      set_in(0, 0, 0, 0, 0, 0, 0); tick();
      n_checks++; if (instruction_ID !== 32'd65) begin n_errors++; $display("FAIL bj_target_instr: got %h expected 65", instruction_ID); end
      n_checks++; if (valid_ID !== 1'b1) begin n_errors++; $display("FAIL bj_one_bubble: got %b expected 1", valid_ID); end
      n_checks++; if (pc_IF !== BASE + 32'h104) begin n_errors++; $display("FAIL bj_next_pc: got %h expected %h", pc_IF, BASE + 32'h104); end
   endtask

   task automatic test_misalign();
      set_in(1, 0, 0, 0, 0, 0, 0); tick();
      set_in(0, 0, 0, 1, BASE + 32'h13, 0, 0); tick();
      n_checks++; if (pc_IF !== BASE + 32'h10) begin n_errors++; $display("FAIL mis_pc: got %h expected %h", pc_IF, BASE + 32'h10); end
      n_checks++; if (misalign_err !== 1'b1) begin n_errors++; $display("FAIL mis_err: got %b expected 1", misalign_err); end
      set_in(0, 0, 0, 0, 0, 0, 0);
      for (int c = 0; c < 10; c++) tick();
      n_checks++; if (misalign_err !== 1'b1) begin n_errors++; $display("FAIL mis_sticky: got %b expected 1", misalign_err); end
   endtask

   task automatic test_flush_stall();
      logic [31:0] pc_before;
      logic [15:0] cnt_before;
      pc_before = pc_IF; cnt_before = fetch_count;
      set_in(0, 0, 0, 0, 0, 1, 1); tick();
      n_checks++; if (pc_IF !== pc_before) begin n_errors++; $display("FAIL fs_pc: got %h expected %h", pc_IF, pc_before); end
      n_checks++; if (valid_ID !== 1'b0) begin n_errors++; $display("FAIL fs_valid: got %b expected 0", valid_ID); end
      n_checks++; if (instruction_ID !== 32'd0) begin n_errors++; $display("FAIL fs_instr: got %h expected 0", instruction_ID); end
      n_checks++; if (fetch_count !== cnt_before) begin n_errors++; $display("FAIL fs_count: got %0d expected %0d", fetch_count, cnt_before); end
      set_in(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_wrap();
      set_in(1, 0, 0, 0, 0, 0, 0); tick();
      set_in(0, 0, 0, 0, 0, 0, 0);
      for (int n = 0; n < 6; n++) begin
         n_checks++; if (w_imem_addr !== 2'(n % 4)) begin n_errors++; $display("FAIL wrap_addr[%0d]: got %0d expected %0d", n, w_imem_addr, n % 4); end
         if (n > 0) begin
            n_checks++; if (w_fetch_count !== 2'(n % 4)) begin n_errors++; $display("FAIL wrap_count[%0d]: got %0d expected %0d", n, w_fetch_count, n % 4); end
            n_checks++; if (w_instruction_ID !== 32'(((n - 1) % 4) + 1)) begin n_errors++; $display("FAIL wrap_instr[%0d]: got %h expected %h", n, w_instruction_ID, 32'(((n - 1) % 4) + 1)); end
         end
         tick();
      end
   endtask

   task automatic test_reset_midrun();
      set_in(0, 0, 0, 0, 0, 0, 0); tick(); tick(); tick();
      set_in(1, 1, BASE + 32'h300, 0, 0, 0, 0); tick();
      n_checks++; if (pc_IF !== BASE) begin n_errors++; $display("FAIL rmid_pc: got %h expected %h", pc_IF, BASE); end
      n_checks++; if (valid_ID !== 1'b0 || instruction_ID !== 32'd0 || pc_plus_4_ID !== 32'd0) begin n_errors++; $display("FAIL rmid_ifid: got %b/%h/%h expected 0/0/0", valid_ID, instruction_ID, pc_plus_4_ID); end
      n_checks++; if (fetch_count !== 16'd0 || misalign_err !== 1'b0) begin n_errors++; $display("FAIL rmid_cnt_err: got %0d/%b expected 0/0", fetch_count, misalign_err); end
      set_in(0, 0, 0, 0, 0, 0, 0); tick();
      n_checks++; if (pc_IF !== BASE + 32'd4) begin n_errors++; $display("FAIL rmid_resume_pc: got %h expected %h", pc_IF, BASE + 32'd4); end
      n_checks++; if (instruction_ID !== rom[0] || valid_ID !== 1'b1) begin n_errors++; $display("FAIL rmid_resume_instr: got %h/%b expected %h/1", instruction_ID, valid_ID, rom[0]); end
   endtask

   task automatic test_random();
      int r;
      logic [31:0] exp_addr;
      for (int k = 0; k < 256; k++) rom[k] = $urandom;
      set_in(1, 0, 0, 0, 0, 0, 0); tick();
      for (int c = 0; c < 400; c++) begin
         r = $urandom_range(0, 99);
         set_in(r < 2, (r >= 2 && r < 10), BASE + 32'($urandom_range(0, 2047)),
                (r >= 6 && r < 18), BASE + 32'($urandom_range(0, 2047)),
                $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
         tick();
         exp_addr = ((m_pc - BASE) / 4) % 256;
         n_checks++; if (pc_IF !== m_pc) begin n_errors++; $display("FAIL rnd_pc[%0d]: got %h expected %h", c, pc_IF, m_pc); end
         n_checks++; if (imem_addr !== exp_addr[7:0]) begin n_errors++; $display("FAIL rnd_addr[%0d]: got %0d expected %0d", c, imem_addr, exp_addr); end
         n_checks++; if (instruction_ID !== m_instr || pc_plus_4_ID !== m_pc4 || valid_ID !== m_valid) begin n_errors++; $display("FAIL rnd_ifid[%0d]: got %h/%h/%b expected %h/%h/%b", c, instruction_ID, pc_plus_4_ID, valid_ID, m_instr, m_pc4, m_valid); end
         n_checks++; if (fetch_count !== 16'(m_count) || misalign_err !== m_err) begin n_errors++; $display("FAIL rnd_cnt_err[%0d]: got %0d/%b expected %0d/%b", c, fetch_count, misalign_err, m_count, m_err); end
      end
   endtask

   initial begin
      fill_rom_seq();
      m_pc = BASE; m_instr = 0; m_pc4 = 0; m_valid = 0; m_count = 0; m_err = 0;
      test_reset();
      test_sequential();
      test_stall();
      test_branch_jump();
      test_misalign();
      test_flush_stall();
      test_wrap();
      test_reset_midrun();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/if_stage_gen2.md
IF_STAGE_GEN2 -- requirements
Module: if_stage_gen2

Interface
REQ-001 Parameter MEMORY_DEPTH, default 256, instruction-memory depth in words, power of two, minimum 4.
REQ-002 Parameter RESET_PC, default 32'h0040_0000, PC value after reset, word-aligned.
REQ-003 Parameter COUNT_W, default 16, width of the delivered-instruction counter.
REQ-004 Local AW = log2(MEMORY_DEPTH).
REQ-005 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-006 Port reset  input  1  synchronous, active-high reset.
REQ-007 Port stall  input  1  hazard stall; hold PC and the IF/ID register.
REQ-008 Port flush  input  1  replace the IF/ID contents with a bubble.
REQ-009 Port branch_taken_M  input  1  branch resolved taken in MEM.
REQ-010 Port branch_target_M  input  32  branch target address.
REQ-011 Port jump_D  input  1  j/jal/jr decoded in ID.
REQ-012 Port jump_target_D  input  32  jump target address.
REQ-013 Port imem_addr  output  AW  word index into the instruction ROM.
REQ-014 Port imem_data  input  32  ROM instruction word, combinational read of imem_addr.
REQ-015 Port pc_IF  output  32  current fetch PC.
REQ-016 Port instruction_ID  output  32  IF/ID instruction.
REQ-017 Port pc_plus_4_ID  output  32  IF/ID PC+4.
REQ-018 Port valid_ID  output  1  IF/ID holds a real instruction.
REQ-019 Port fetch_count  output  COUNT_W  number of valid instructions delivered to ID.
REQ-020 Port misalign_err  output  1  sticky flag: a redirect target had bits [1:0] != 0.

Function
REQ-021 imem_addr SHALL equal ((pc_IF - RESET_PC) >> 2) truncated to AW bits, so word indices wrap modulo MEMORY_DEPTH.
REQ-022 The next-PC priority SHALL be: branch_taken_M, then jump_D, then stall (hold), then pc_IF+4 with 32-bit wrap-around.
REQ-023 A redirect (branch_taken_M or jump_D) SHALL override stall.
REQ-024 The PC SHALL load the selected target with bits [1:0] forced to 0.
REQ-025 misalign_err SHALL set to 1 when the selected target has bits [1:0] != 0, and SHALL stay set until reset.
REQ-026 On redirect or flush, the IF/ID register SHALL load instruction_ID=0 (NOP), pc_plus_4_ID=0 and valid_ID=0.
REQ-027 With stall and no redirect or flush, the IF/ID register SHALL hold its value.
REQ-028 Otherwise the IF/ID register SHALL load instruction_ID=imem_data, pc_plus_4_ID=pc_IF+4 and valid_ID=1.
REQ-029 Latency: the word fetched while pc_IF==A SHALL appear on instruction_ID one cycle later.
REQ-030 A redirect SHALL cost exactly one bubble in ID.
REQ-031 fetch_count SHALL increment by 1 in each cycle the IF/ID register loads with valid_ID=1.
REQ-032 fetch_count SHALL wrap from 2^COUNT_W-1 to 0.
REQ-033 When branch_taken_M and jump_D are asserted together, the branch target SHALL be used and the jump SHALL be discarded.
REQ-034 When flush and stall are asserted together, flush SHALL win; the PC SHALL still hold unless a redirect is present.

Reset
REQ-035 While reset is high at a clock edge: pc_IF=RESET_PC, instruction_ID=0, pc_plus_4_ID=0, valid_ID=0, fetch_count=0, misalign_err=0.
REQ-036 Reset SHALL take priority over every other input, including a redirect in the same cycle.
REQ-037 Reset asserted mid-stream SHALL discard the in-flight instruction with no partial update.
REQ-038 Fetch SHALL resume at RESET_PC on the first edge after reset deasserts.

Verification
REQ-039 Sequential run: release reset, ROM word k = k+1 -> cycle n: pc_IF=0x0040_0000+4n; next cycle instruction_ID=n+1, valid_ID=1; fetch_count=n after n loads.
REQ-040 Stall: assert stall for 3 cycles with pc_IF=0x0040_0008 -> pc_IF and instruction_ID frozen, fetch_count unchanged; resumes at 0x0040_000C.
REQ-041 Branch vs jump: branch_taken_M=1 (target 0x0040_0100) with jump_D=1 (target 0x0040_0200) and stall=1 -> pc_IF=0x0040_0100, imem_addr=64, next ID is a bubble (valid_ID=0, instruction 0).
REQ-042 Misaligned jump: jump_target_D=0x0040_0013 -> pc_IF=0x0040_0010, misalign_err=1 and still 1 after 10 further cycles.
REQ-043 Wrap: MEMORY_DEPTH=4, 6 sequential fetches -> imem_addr sequence 0,1,2,3,0,1; COUNT_W=2 -> fetch_count 1,2,3,0,1.
REQ-044 Reset mid-run: reset=1 together with branch_taken_M=1 -> pc_IF=0x0040_0000, all outputs at their reset values.
